// File: rtl/kikei_mem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the responder state encoding, the word/byte geometry and the
// latency counter width. There are no ports.
package kikei_mem_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int LANES  = WORD_W / BYTE_W;
    // Wide enough for LATENCY up to 15.
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_lane_mux.sv
// Byte-lane extract and merge for the data-memory responder.
// Loads: select either the full word or one zero-extended byte lane.
// Stores: produce either the new full word or the old word with one lane
// replaced by the low byte of the store data. Lanes are little-endian, so
// lane 0 is bits [7:0].
//
// Ports
//   i_word       stored word at the addressed index
//   i_lane       byte lane, DataAdr[1:0]
//   i_be         1 = byte access, 0 = word access
//   i_wdata      store data; byte stores use [7:0]
//   o_load_data  load result
//   o_merge_word word to write back for a store
module dmem_lane_mux
    import kikei_mem_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    input  logic [1:0]        i_lane,
    input  logic              i_be,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_load_data,
    output logic [WORD_W-1:0] o_merge_word
);

    logic [BYTE_W-1:0] w_byte;
    logic [4:0]        w_bit_base;

    always_comb begin
        w_bit_base   = {i_lane, 3'b000};
        w_byte       = i_word[w_bit_base +: BYTE_W];
        o_load_data  = i_word;
        o_merge_word = i_wdata;
        if (i_be) begin
            o_load_data  = {{(WORD_W-BYTE_W){1'b0}}, w_byte};
            o_merge_word = i_word;
            o_merge_word[w_bit_base +: BYTE_W] = i_wdata[BYTE_W-1:0];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with a word-organised backing store.
// One request is accepted in IDLE, answered LATENCY cycles later with a
// one-cycle resp_valid pulse, then the block returns to IDLE. Stores commit
// on the edge that ends RESP. The memory array is never reset.
//
// Ports
//   clk         single clock, rising edge
//   reset       synchronous active-high reset
//   req_valid   request present
//   req_ready   request can be accepted (IDLE only)
//   MemWrite    1 = store, 0 = load
//   be          1 = byte access, 0 = word access
//   DataAdr     byte address; upper bits beyond the array alias
//   WriteData   store data
//   resp_valid  one-cycle response pulse
//   ReadData    load data during a load response, otherwise 0
//   stall       busy between accept and response
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | request captured, latency counter running
// RESP  | response cycle; store commits at the end of it
module dmem_responder
    import kikei_mem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              MemWrite,
    input  logic              be,
    input  logic [WORD_W-1:0] DataAdr,
    input  logic [WORD_W-1:0] WriteData,
    output logic              resp_valid,
    output logic [WORD_W-1:0] ReadData,
    output logic              stall
);

    localparam int              AW         = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] C_LAT_LAST = CNT_W'(LATENCY - 1);

    dmem_state_t       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic              r_be;
    logic [AW-1:0]     r_idx;
    logic [1:0]        r_lane;
    logic [WORD_W-1:0] r_wdata;
    logic              r_req_ready;
    logic              r_stall;
    logic              r_resp_valid;
    logic [WORD_W-1:0] r_read_data;
    logic [WORD_W-1:0] r_mem [DEPTH];

    logic [AW-1:0]     w_idx;
    logic [1:0]        w_lane;
    logic              w_be;
    logic [WORD_W-1:0] w_mem_word;
    logic [WORD_W-1:0] w_load_data;
    logic [WORD_W-1:0] w_merge_word;
    logic              w_commit;
    logic              w_unused_adr;

    assign w_unused_adr = &{1'b0, DataAdr[WORD_W-1:AW+2]};

    // In IDLE the lane mux looks at the live request so a LATENCY=1 load can
    // register its data on the accept edge; afterwards it uses the capture.
    assign w_idx      = (r_state == IDLE) ? DataAdr[AW+1:2] : r_idx;
    assign w_lane     = (r_state == IDLE) ? DataAdr[1:0]    : r_lane;
    assign w_be       = (r_state == IDLE) ? be              : r_be;
    assign w_mem_word = r_mem[w_idx];

    dmem_lane_mux u_lane_mux (
        .i_word       (w_mem_word),
        .i_lane       (w_lane),
        .i_be         (w_be),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_word (w_merge_word)
    );

    // A reset on the closing edge of RESP aborts the store.
    assign w_commit = (r_state == RESP) && r_we && !reset;

    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[r_idx] <= w_merge_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_be         <= 1'b0;
            r_idx        <= '0;
            r_lane       <= '0;
            r_wdata      <= '0;
            r_req_ready  <= 1'b1;
            r_stall      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_read_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we        <= MemWrite;
                        r_be        <= be;
                        r_idx       <= DataAdr[AW+1:2];
                        r_lane      <= DataAdr[1:0];
                        r_wdata     <= WriteData;
                        r_cnt       <= CNT_W'(1);
                        r_req_ready <= 1'b0;
                        r_stall     <= 1'b1;
                        if (LATENCY == 1) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_read_data  <= MemWrite ? '0 : w_load_data;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == C_LAT_LAST) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_read_data  <= r_we ? '0 : w_load_data;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_state      <= IDLE;
                    r_cnt        <= '0;
                    r_req_ready  <= 1'b1;
                    r_stall      <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_read_data  <= '0;
                end
                default: begin
                    r_state      <= IDLE;
                    r_cnt        <= '0;
                    r_req_ready  <= 1'b1;
                    r_stall      <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_read_data  <= '0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign stall      = r_stall;
    assign resp_valid = r_resp_valid;
    assign ReadData   = r_read_data;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: u_a is the default build (DEPTH=64, LATENCY=2),
// u_b a LATENCY=1 build sharing clock and reset.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        a_req_valid, a_req_ready, a_mem_write, a_be, a_resp_valid, a_stall;
    logic [31:0] a_adr, a_wdata, a_rdata;
    logic        b_req_valid, b_req_ready, b_mem_write, b_be, b_resp_valid, b_stall;
    logic [31:0] b_adr, b_wdata, b_rdata;

    dmem_responder #(.DEPTH(64), .LATENCY(2)) u_a (
        .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .MemWrite(a_mem_write), .be(a_be), .DataAdr(a_adr), .WriteData(a_wdata),
        .resp_valid(a_resp_valid), .ReadData(a_rdata), .stall(a_stall)
    );

    dmem_responder #(.DEPTH(64), .LATENCY(1)) u_b (
        .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .MemWrite(b_mem_write), .be(b_be), .DataAdr(b_adr), .WriteData(b_wdata),
        .resp_valid(b_resp_valid), .ReadData(b_rdata), .stall(b_stall)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic txn_a(input logic we, input logic b, input logic [31:0] adr,
                         input logic [31:0] wd, input logic [31:0] exp, input string name);
        int lat;
        @(negedge clk);
        a_req_valid = 1'b1; a_mem_write = we; a_be = b; a_adr = adr; a_wdata = wd;
        check({name, "_ready"}, 32'(a_req_ready), 32'd1);
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!a_resp_valid) check({name, "_stall_wait"}, 32'(a_stall), 32'd1);
        end while (!a_resp_valid && lat < 8);
        check({name, "_latency"}, 32'(lat), 32'd2);
        check({name, "_data"}, a_rdata, we ? 32'h0 : exp);
        check({name, "_stall_resp"}, 32'(a_stall), 32'd1);
        @(negedge clk);
        check({name, "_idle"}, {29'd0, a_req_ready, a_stall, a_resp_valid}, 32'b100);
        check({name, "_rdata_zero"}, a_rdata, 32'h0);
    endtask

    task automatic txn_b(input logic we, input logic b, input logic [31:0] adr,
                         input logic [31:0] wd, input logic [31:0] exp, input string name);
        @(negedge clk);
        b_req_valid = 1'b1; b_mem_write = we; b_be = b; b_adr = adr; b_wdata = wd;
        check({name, "_ready"}, 32'(b_req_ready), 32'd1);
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        @(negedge clk);
        check({name, "_resp"}, {29'd0, b_req_ready, b_stall, b_resp_valid}, 32'b011);
        check({name, "_data"}, b_rdata, we ? 32'h0 : exp);
        @(negedge clk);
        check({name, "_idle"}, {29'd0, b_req_ready, b_stall, b_resp_valid}, 32'b100);
    endtask

    typedef struct packed {
        logic        we;
        logic        b;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14];

    logic [31:0] s_adr [3];
    logic [31:0] s_exp [3];
    int          acc_cyc [3];

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacc, nresp, extra;
        bit took;

        reset = 1'b1;
        a_req_valid = 0; a_mem_write = 0; a_be = 0; a_adr = 0; a_wdata = 0;
        b_req_valid = 0; b_mem_write = 0; b_be = 0; b_adr = 0; b_wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_flags", {29'd0, a_req_ready, a_stall, a_resp_valid}, 32'b100);
        check("rst_a_rdata", a_rdata, 32'h0);
        check("rst_b_flags", {29'd0, b_req_ready, b_stall, b_resp_valid}, 32'b100);
        reset = 1'b0;

        //          we    be    adr           wd            exp
        vecs[0]  = {1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = {1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        vecs[2]  = {1'b1, 1'b1, 32'h0000_0012, 32'hAAAA_AA55, 32'h0};
        vecs[3]  = {1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDE55_BEEF};
        vecs[4]  = {1'b0, 1'b1, 32'h0000_0013, 32'h0,         32'h0000_00DE};
        vecs[5]  = {1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'h0000_00EF};
        vecs[6]  = {1'b0, 1'b0, 32'h0000_0011, 32'h0,         32'hDE55_BEEF};
        vecs[7]  = {1'b1, 1'b0, 32'h0000_0000, 32'h1234_5678, 32'h0};
        vecs[8]  = {1'b0, 1'b0, 32'h0000_0100, 32'h0,         32'h1234_5678};
        vecs[9]  = {1'b1, 1'b1, 32'h0000_0103, 32'h0000_00A5, 32'h0};
        vecs[10] = {1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'hA534_5678};
        vecs[11] = {1'b0, 1'b1, 32'h0000_0101, 32'h0,         32'h0000_0056};
        vecs[12] = {1'b1, 1'b0, 32'h0000_0020, 32'h1122_3344, 32'h0};
        vecs[13] = {1'b0, 1'b1, 32'h0000_0022, 32'h0,         32'h0000_0022};

        for (int i = 0; i < 14; i++) begin
            txn_a(vecs[i].we, vecs[i].b, vecs[i].adr, vecs[i].wd, vecs[i].exp,
                  $sformatf("vec%0d", i));
        end

        // Back-to-back loads with req_valid held high.
        s_adr[0] = 32'h10; s_adr[1] = 32'h0;          s_adr[2] = 32'h20;
        s_exp[0] = 32'hDE55_BEEF; s_exp[1] = 32'hA534_5678; s_exp[2] = 32'h1122_3344;
        nacc = 0; nresp = 0;
        @(negedge clk);
        a_req_valid = 1'b1; a_mem_write = 1'b0; a_be = 1'b0; a_adr = s_adr[0];
        for (int cyc = 0; cyc < 30 && nresp < 3; cyc++) begin
            took = 1'b0;
            if (a_resp_valid) begin
                check($sformatf("hold_data%0d", nresp), a_rdata, s_exp[nresp]);
                nresp++;
            end
            if (a_req_ready && a_req_valid) begin
                if (nacc < 3) acc_cyc[nacc] = cyc;
                nacc++;
                took = 1'b1;
            end else begin
                check("hold_busy", {30'd0, a_req_ready, a_stall}, 32'b01);
            end
            @(posedge clk); #1;
            if (took) begin
                if (nacc < 3) a_adr = s_adr[nacc];
                else a_req_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("hold_accepts", 32'(nacc), 32'd3);
        check("hold_resps", 32'(nresp), 32'd3);
        if (nacc >= 3) begin
            check("hold_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            check("hold_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        end
        extra = 0;
        repeat (4) begin
            if (a_resp_valid) extra++;
            @(negedge clk);
        end
        check("hold_no_extra", 32'(extra), 32'd0);

        // Reset during WAIT aborts a store.
        @(negedge clk);
        a_req_valid = 1'b1; a_mem_write = 1'b1; a_be = 1'b0; a_adr = 32'h20; a_wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        check("rstw_in_wait", {30'd0, a_req_ready, a_stall}, 32'b01);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstw_after", {29'd0, a_req_ready, a_stall, a_resp_valid}, 32'b100);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (a_resp_valid) extra++;
        end
        check("rstw_no_resp", 32'(extra), 32'd0);
        txn_a(1'b0, 1'b0, 32'h20, 32'h0, 32'h1122_3344, "rstw_load");

        // Reset during RESP drops the store commit.
        @(negedge clk);
        a_req_valid = 1'b1; a_mem_write = 1'b1; a_be = 1'b0; a_adr = 32'h20; a_wdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        @(posedge clk); #1;
        check("rstr_in_resp", 32'(a_resp_valid), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstr_after", {29'd0, a_req_ready, a_stall, a_resp_valid}, 32'b100);
        txn_a(1'b0, 1'b0, 32'h20, 32'h0, 32'h1122_3344, "rstr_load");

        // LATENCY=1 build.
        txn_b(1'b1, 1'b0, 32'h4, 32'hCAFE_F00D, 32'h0,         "l1_st");
        txn_b(1'b0, 1'b0, 32'h4, 32'h0,         32'hCAFE_F00D, "l1_ld");
        txn_b(1'b0, 1'b1, 32'h6, 32'h0,         32'h0000_00FE, "l1_ldb");
        txn_b(1'b1, 1'b1, 32'h5, 32'h0000_0077, 32'h0,         "l1_stb");
        txn_b(1'b0, 1'b0, 32'h4, 32'h0,         32'hCAFE_770D, "l1_ld2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of 32-bit words in the backing store (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to response (1..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  core presents a data-memory request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port MemWrite  input  1  1 = store, 0 = load.
REQ-008 SHALL have port be  input  1  1 = byte access (LDRB/STRB), 0 = word access.
REQ-009 SHALL have port DataAdr  input  32  byte address.
REQ-010 SHALL have port WriteData  input  32  store data; byte stores use bits [7:0].
REQ-011 SHALL have port resp_valid  output  1  one-cycle pulse marking load data valid or store complete.
REQ-012 SHALL have port ReadData  output  32  load result, valid only while resp_valid=1.
REQ-013 SHALL have port stall  output  1  request accepted and response not yet delivered.

Function
REQ-014 SHALL accept a request on a rising edge where req_valid=1 and req_ready=1, capturing MemWrite, be, DataAdr, WriteData.
REQ-015 SHALL implement states IDLE, WAIT, RESP: IDLE->WAIT on accept; WAIT->RESP when the latency counter reaches LATENCY-1; RESP->IDLE unconditionally. When LATENCY=1, SHALL go IDLE->RESP directly.
REQ-016 SHALL drive req_ready=1 only in IDLE; stall=1 in WAIT and RESP.
REQ-017 SHALL assert resp_valid exactly LATENCY cycles after the acceptance cycle, for one cycle (state RESP); throughput is one request per LATENCY+1 cycles.
REQ-018 SHALL index words by captured DataAdr[log2(DEPTH)+1:2]; upper address bits are ignored (alias wrap-around).
REQ-019 Word load SHALL return the full stored word; DataAdr[1:0] ignored.
REQ-020 Byte load SHALL return the byte at lane DataAdr[1:0] (little-endian, lane 0 = bits [7:0]), zero-extended to 32 bits.
REQ-021 Word store SHALL replace the full word; byte store SHALL replace only lane DataAdr[1:0] with WriteData[7:0], other lanes unchanged.
REQ-022 Stores SHALL commit on the rising edge ending state RESP; a load issued immediately afterwards SHALL observe the new value.
REQ-023 ReadData SHALL be 0 whenever resp_valid=0, and 0 during store responses.
REQ-024 req_valid asserted while busy SHALL be ignored (not queued).

Reset
REQ-025 On reset: state=IDLE, counter=0, req_ready=1 in the following cycle, resp_valid=0, stall=0, ReadData=0.
REQ-026 Reset during WAIT or RESP SHALL abort the operation with no response and no store committed.
REQ-027 Reset SHALL NOT clear the memory array; contents are retained.

Structure
REQ-028 Shared package kikei_mem_pkg SHALL hold the state enum (IDLE, WAIT, RESP) and word/byte width constants.
REQ-029 Lane merge/extract logic SHALL be one combinational sub-module dmem_lane_mux (byte select for loads, byte merge for stores).

Verification
REQ-030 Store word 0xDEADBEEF @0x10, then load word @0x10 (LATENCY=2) -> resp_valid 2 cycles after each accept, ReadData=0xDEADBEEF.
REQ-031 After REQ-030, byte store 0x55 @0x12 -> word @0x10 reads 0xDE55BEEF; byte load @0x13 -> 0x000000DE.
REQ-032 Hold req_valid=1 continuously with 3 loads -> accepts separated by 3 cycles, req_ready=0 and stall=1 between, no dropped or duplicate responses.
REQ-033 Store 0x12345678 @0x0, load @(DEPTH*4) -> ReadData=0x12345678 (alias wrap).
REQ-034 Store 0xFFFFFFFF @0x20 accepted, reset asserted in WAIT -> no resp_valid; subsequent load @0x20 returns prior contents.
REQ-035 LATENCY=1 build: load accept -> resp_valid next cycle, req_ready back one cycle later.
